// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 3-bit 1-to-2 stream demultiplexer.
package demux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 8;

  // Pointer width for a FIFO of the given depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/demux_3bit_1to2_stream_if.sv
// Stream bundle of the demultiplexer: one tagged input stream, two output channels.
interface demux_3bit_1to2_stream_if
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [CNT_W-1:0] a_count;

  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CNT_W-1:0] b_count;

  modport slave (
    input  in_data, in_sel, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, a_count, b_data, b_valid, b_count
  );

  modport master (
    output in_data, in_sel, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, a_count, b_data, b_valid, b_count
  );

endinterface

// File: rtl/demux_fifo.sv
// Small synchronous circular-buffer FIFO used as the per-channel output buffer.
module demux_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ == OCC_FULL);
  assign empty   = (occ == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      // NOTE: storage is cleared too so the head read after reset is 0, not X.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/demux_3bit_1to2_stream.sv
// Registered 1-to-2 stream demultiplexer: steers tagged items into two buffered
// channels, each with a saturating delivered-item counter.
module demux_3bit_1to2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                     clk,
  input logic                     reset,
  demux_3bit_1to2_stream_if.slave bus
);

  logic             a_full, a_empty, b_full, b_empty;
  logic             in_fire, push_a, push_b, pop_a, pop_b;
  logic [CNT_W-1:0] a_count_q, b_count_q;

  // Only the selected channel's occupancy gates the input; no pass-through when full.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    bus.in_ready = 1'b0;
    if (!reset) begin
      bus.in_ready = (bus.in_sel == SEL_B) ? !b_full : !a_full;
    end
  end

  assign in_fire = bus.in_valid && bus.in_ready;
  assign push_a  = in_fire && (bus.in_sel == SEL_A);
  assign push_b  = in_fire && (bus.in_sel == SEL_B);
  assign pop_a   = !a_empty && bus.a_ready;
  assign pop_b   = !b_empty && bus.b_ready;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .reset     (reset),
    .push      (push_a),
    .pop       (pop_a),
    .push_data (bus.in_data),
    .full      (a_full),
    .empty     (a_empty),
    .head      (bus.a_data)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .reset     (reset),
    .push      (push_b),
    .pop       (pop_b),
    .push_data (bus.in_data),
    .full      (b_full),
    .empty     (b_empty),
    .head      (bus.b_data)
  );

  assign bus.a_valid = !a_empty;
  assign bus.b_valid = !b_empty;

  // Counters hold at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      if (pop_a && (a_count_q != '1)) a_count_q <= a_count_q + 1'b1;
      if (pop_b && (b_count_q != '1)) b_count_q <= b_count_q + 1'b1;
    end
  end

  assign bus.a_count = a_count_q;
  assign bus.b_count = b_count_q;

endmodule

// File: tb/tb_demux_3bit_1to2_stream.sv
// Self-checking bench: vector table plus hand sequences, with per-channel scoreboards.
module tb_demux_3bit_1to2_stream;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  demux_3bit_1to2_stream_if #(.WIDTH(3), .CNT_W(8)) u_if ();
  demux_3bit_1to2_stream_if #(.WIDTH(3), .CNT_W(2)) u_if2 ();

  demux_3bit_1to2_stream #(.WIDTH(3), .DEPTH(2), .CNT_W(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  demux_3bit_1to2_stream #(.WIDTH(3), .DEPTH(2), .CNT_W(2)) u_dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if2.slave)
  );

  typedef struct {
    logic [2:0] data;
    logic       sel;
    logic       valid;
    logic       a_rdy;
    logic       b_rdy;
    logic       exp_rdy;
    logic       exp_av;
    logic       exp_bv;
  } vec_t;

  vec_t       vecs [15];
  logic [2:0] q_a [$];
  logic [2:0] q_b [$];
  logic [7:0] exp_a_cnt = '0;
  logic [7:0] exp_b_cnt = '0;
  int         checks = 0;
  int         passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [2:0] d, input logic s,
                       input logic ar, input logic br);
    u_if.in_valid = v;
    u_if.in_data  = d;
    u_if.in_sel   = s;
    u_if.a_ready  = ar;
    u_if.b_ready  = br;
  endtask

  // One full cycle: settle, score transfers of u_if, cross the rising edge, return at falling edge.
  task automatic tick();
    logic [2:0] exp;
    #1;
    check("a_count", u_if.a_count, exp_a_cnt);
    check("b_count", u_if.b_count, exp_b_cnt);
    if (!reset) begin
      if (u_if.in_valid && u_if.in_ready) begin
        if (u_if.in_sel) q_b.push_back(u_if.in_data);
        else             q_a.push_back(u_if.in_data);
      end
      if (u_if.a_valid && u_if.a_ready) begin
        if (q_a.size() == 0) check("a_unexpected_item", q_a.size(), 1);
        else begin
          exp = q_a.pop_front();
          check("a_data", u_if.a_data, exp);
        end
        if (exp_a_cnt != 8'hFF) exp_a_cnt++;
      end
      if (u_if.b_valid && u_if.b_ready) begin
        if (q_b.size() == 0) check("b_unexpected_item", q_b.size(), 1);
        else begin
          exp = q_b.pop_front();
          check("b_data", u_if.b_data, exp);
        end
        if (exp_b_cnt != 8'hFF) exp_b_cnt++;
      end
    end
    @(posedge clk);
    if (reset) begin
      q_a.delete();
      q_b.delete();
      exp_a_cnt = '0;
      exp_b_cnt = '0;
    end
    @(negedge clk);
  endtask

  initial begin
    //           data    sel   vld   ardy  brdy  rdy   av    bv
    // alternating traffic, both consumers ready
    vecs[0]  = '{3'b101, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{3'b101, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    // channel A stalled: absorbs two items, third blocks, B still flows
    vecs[6]  = '{3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{3'b110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{3'b011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{3'b011, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{3'b011, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    drive(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    u_if2.in_valid = 1'b0;
    u_if2.in_data  = '0;
    u_if2.in_sel   = 1'b1;
    u_if2.a_ready  = 1'b0;
    u_if2.b_ready  = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held with in_valid high.
    repeat (2) begin
      #1;
      check("rst_in_ready", u_if.in_ready, 0);
      check("rst_a_valid", u_if.a_valid, 0);
      check("rst_b_valid", u_if.b_valid, 0);
      check("rst_a_data", u_if.a_data, 0);
      check("rst_b_data", u_if.b_data, 0);
      tick();
    end

    // First cycle after release accepts; item visible the next cycle.
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", u_if.in_ready, 1);
    tick();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("latency_a_valid", u_if.a_valid, 1);
    check("latency_a_data", u_if.a_data, 7);
    u_if.a_ready = 1'b1;
    tick();

    // Vector table.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].valid, vecs[i].data, vecs[i].sel, vecs[i].a_rdy, vecs[i].b_rdy);
      #1;
      check($sformatf("vec%0d_in_ready", i), u_if.in_ready, vecs[i].exp_rdy);
      check($sformatf("vec%0d_a_valid", i), u_if.a_valid, vecs[i].exp_av);
      check($sformatf("vec%0d_b_valid", i), u_if.b_valid, vecs[i].exp_bv);
      tick();
    end

    // Simultaneous push and pop at occupancy 1 keeps occupancy at 1.
    drive(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
    #1;
    check("pp_in_ready", u_if.in_ready, 1);
    tick();
    drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    #1;
    check("pp_head_valid", u_if.a_valid, 1);
    check("pp_head_data", u_if.a_data, 4);
    check("pp_occ_one", u_if.in_ready, 1);
    tick();
    drive(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    #1;
    check("pp_occ_full", u_if.in_ready, 0);
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    #1;
    check("pp_drained", u_if.a_valid, 0);
    tick();

    // Counter saturation on the narrow-counter instance.
    for (int i = 0; i < 7; i++) begin
      u_if2.in_valid = (i < 5);
      u_if2.in_data  = 3'(i);
      u_if2.in_sel   = 1'b1;
      u_if2.b_ready  = 1'b1;
      tick();
      if (i >= 1) begin
        #1;
        check($sformatf("sat_b_count_%0d", i), u_if2.b_count, (i < 3) ? i : 3);
      end
    end
    u_if2.in_valid = 1'b0;

    // Reset with both channels full discards everything.
    drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 3'd3, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 3'd4, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    #1;
    check("full_a_in_ready", u_if.in_ready, 0);
    check("full_a_valid", u_if.a_valid, 1);
    check("full_b_valid", u_if.b_valid, 1);
    reset = 1'b1;
    drive(1'b1, 3'd5, 1'b0, 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    #1;
    check("flush_a_valid", u_if.a_valid, 0);
    check("flush_b_valid", u_if.b_valid, 0);
    check("flush_a_data", u_if.a_data, 0);
    check("flush_b_data", u_if.b_data, 0);
    check("flush_a_count", u_if.a_count, 0);
    check("flush_b_count", u_if.b_count, 0);
    check("flush_sat_count", u_if2.b_count, 0);
    repeat (3) tick();

    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/demux_3bit_1to2_stream.md
# demux_3bit_1to2_stream

Registered 3-bit 1-to-2 demultiplexer: the receive-side counterpart of the team's 3-bit 2-to-1 multiplexer. It accepts a valid/ready stream of 3-bit items, each tagged with a select bit. It steers each item into one of two buffered output channels (A for select=0, B for select=1). Each channel has its own small FIFO and a delivered-item counter. It sits after a muxed link to split the shared 3-bit path back into two independent consumers.

## Interface
- WIDTH, 3, item data width.
- DEPTH, 2, entries per channel FIFO; power of two, 2 or more.
- CNT_W, 8, width of each delivered-item counter.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  item to route.
- in_sel  input  1  0 routes to channel A, 1 routes to channel B.
- in_valid  input  1  item present.
- in_ready  output  1  block accepts the item this cycle.
- a_data / b_data  output  WIDTH  head item of the channel FIFO.
- a_valid / b_valid  output  1  channel FIFO non-empty.
- a_ready / b_ready  input  1  consumer takes the head item.
- a_count / b_count  output  CNT_W  items delivered on the channel; saturating.

## Operation
- Transfer rules:
  - An input transfer happens when in_valid and in_ready are both high.
  - An output transfer on channel X happens when x_valid and x_ready are both high.
- in_ready is combinational: high when not reset and the FIFO selected by in_sel is not full.
  - The state of the unselected channel never blocks input.
  - There is no pass-through when the selected FIFO is full. A pop in the same cycle does not free space for that cycle's push.
- in_valid must hold in_data and in_sel stable until the transfer completes. The block does not check this.
- Each channel FIFO is a circular buffer with a write pointer, a read pointer and an occupancy count.
  - Occupancy range: 0..DEPTH.
  - full = (occupancy == DEPTH); empty = (occupancy == 0).
  - Pointers wrap from DEPTH-1 to 0.
- Push and pop in the same cycle on a non-empty, non-full FIFO: occupancy unchanged, both pointers advance.
- Pop on an empty FIFO is impossible because x_valid is low. x_ready is ignored in that case.
- x_data is the entry at the read pointer. When empty its value is don't-care, but it must not be X after reset (storage resets to 0).
- x_count increments by 1 on each output transfer of channel X. It saturates at 2^CNT_W-1 and never wraps.
- Reset behaviour:
  - Synchronous reset clears pointers, occupancies, storage and counters.
  - Reset applied mid-stream discards all buffered items. No output transfer completes in a reset cycle.
- Reset values of outputs:
  - in_ready = 0 while reset is high, then 1.
  - a_valid = b_valid = 0.
  - a_data = b_data = 0.
  - a_count = b_count = 0.

## Timing
- Latency: an item accepted at edge N appears on x_valid/x_data in the cycle after edge N.
- Throughput: one item per cycle into each channel while the consumer keeps x_ready high. Sustained input rate is 1/cycle.
- With the consumer stalled, a channel absorbs exactly DEPTH items, then in_ready drops for that select value only.
- The first cycle after reset deasserts can accept an item.
- The counter updates at the same edge as the output transfer and is visible the following cycle.

## Structure
- Shared package demux_pkg:
  - constants SEL_A = 1'b0 and SEL_B = 1'b1;
  - default WIDTH / DEPTH / CNT_W;
  - a function returning the pointer width from DEPTH.
- Sub-module demux_fifo (WIDTH, DEPTH):
  - synchronous FIFO with push, pop, full, empty and head data;
  - instantiated twice.
- Top level holds the select decode, in_ready logic and the two saturating counters.

## Test plan
- Reset held 3 cycles with in_valid=1 -> in_ready=0, a_valid=b_valid=0, counts 0, data 0; the first item after release is accepted.
- Alternating items 3'b101 (sel 0) and 3'b010 (sel 1), both consumers ready -> a_data=101 and b_data=010 each valid one cycle after acceptance; a_count and b_count increment in step.
- a_ready=0, push three sel-0 items 1,2,3 -> first two accepted, in_ready low on the third; a sel-1 item is accepted meanwhile; releasing a_ready yields 1, 2, then 3 in order.
- FIFO at occupancy 1 with simultaneous push of 4 and pop -> occupancy stays 1; the next head is 4 and is valid on the following cycle.
- With CNT_W=2, deliver 5 items on channel B -> b_count reads 1, 2, 3, 3, 3.
- Reset asserted with both FIFOs full -> next cycle a_valid=b_valid=0 and counts 0; buffered items are never presented.
